// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver front end: input synchroniser, free-running 16x oversampling
// tick, deframing FSM with done/frame-error strobes and break handling.
module uart_rx_frontend #(
  parameter int NB_DATA    = 8,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_uart_rx_data,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error,
  output logic               o_busy
);

  localparam int DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int BIT_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB_DATA - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  logic               rx_meta_r;
  logic               rx_sync_r;
  logic [DIV_W-1:0]   div_cnt_r;
  logic               tick_s;
  state_t             state_r;
  logic [3:0]         tick_cnt_r;
  logic [BIT_W-1:0]   bit_idx_r;
  logic [NB_DATA-1:0] shift_r;
  logic [NB_DATA-1:0] rx_data_r;
  logic               rx_done_r;
  logic               frame_err_r;
  logic               busy_r;

  // Two-flop synchroniser; flops reset to the idle (high) line level.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_uart_rx_data;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Free-running oversampling divider; never realigned to the frame.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick_s = (div_cnt_r == DIV_LAST);

  // Deframing FSM; strobes default low so they last exactly one clock.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= IDLE;
      tick_cnt_r  <= 4'd0;
      bit_idx_r   <= '0;
      shift_r     <= '0;
      rx_data_r   <= '0;
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r    <= START;
            tick_cnt_r <= 4'd0;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (tick_s) begin
            if (tick_cnt_r == 4'd7) begin
              tick_cnt_r <= 4'd0;
              bit_idx_r  <= '0;
              if (!rx_sync_r) begin
                state_r <= DATA;
              end else begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_s) begin
            if (tick_cnt_r == 4'd15) begin
              // Right shift: the first (LSB) bit ends up in bit 0.
              shift_r    <= {rx_sync_r, shift_r[NB_DATA-1:1]};
              tick_cnt_r <= 4'd0;
              if (bit_idx_r == BIT_LAST) begin
                state_r   <= STOP;
                bit_idx_r <= '0;
              end else begin
                bit_idx_r <= bit_idx_r + {{(BIT_W-1){1'b0}}, 1'b1};
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick_s) begin
            if (tick_cnt_r == 4'd15) begin
              tick_cnt_r <= 4'd0;
              if (rx_sync_r) begin
                rx_data_r <= shift_r;
                rx_done_r <= 1'b1;
                state_r   <= IDLE;
                busy_r    <= 1'b0;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= BREAK;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 4'd1;
            end
          end
        end
        BREAK: begin
          // Hold here while the line stays low so a break yields one error only.
          if (rx_sync_r) begin
            state_r    <= IDLE;
            tick_cnt_r <= 4'd0;
            busy_r     <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          tick_cnt_r <= 4'd0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data     = rx_data_r;
  assign o_rx_done     = rx_done_r;
  assign o_frame_error = frame_err_r;
  assign o_busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: directed frames push expected events,
// a negedge monitor pops and compares on every done / frame-error strobe.
module tb_uart_rx_frontend;

  localparam int BIT_CLKS = 64;

  logic       clk;
  logic       rst;
  logic       line;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         chk_cnt;
  int         pass_cnt;
  logic [7:0] model_data;

  uart_rx_frontend #(
    .NB_DATA   (8),
    .CLK_FREQ  (640_000),
    .BAUD_RATE (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_uart_rx_data(line),
    .o_rx_data     (rx_data),
    .o_rx_done     (rx_done),
    .o_frame_error (frame_err),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && (rx_done || frame_err)) begin
      if (rx_done && frame_err) begin
        chk_cnt++;
        $display("FAIL strobe_exclusive: done=1 err=1 together, required at most one");
      end else if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_event: done=%0b err=%0b data=%02h, required none",
                 rx_done, frame_err, rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk_cnt++;
        if (frame_err == e.is_err) pass_cnt++;
        else $display("FAIL event_kind: err=%0b, required err=%0b", frame_err, e.is_err);
        chk_cnt++;
        if (rx_data == e.data) pass_cnt++;
        else $display("FAIL event_data: rx_data=%02h, required %02h", rx_data, e.data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    line = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      hold(BIT_CLKS);
    end
    line = stop;
    hold(BIT_CLKS);
  endtask

  task automatic expect_done(input logic [7:0] d);
    exp_q.push_back('{is_err: 1'b0, data: d});
    model_data = d;
  endtask

  // Bounded wait for outstanding expected events; expiry is a failure.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    model_data = 8'h00;
    line       = 1'b1;
    rst        = 1'b1;
    hold(4);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_done", rx_done, 1'b0);
    check("reset_err", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    hold(BIT_CLKS);

    // 1: single valid frame
    expect_done(8'h55);
    send_frame(8'h55, 1'b1);
    drain("t1_drain");
    check("t1_data", rx_data, 8'h55);
    hold(BIT_CLKS);

    // 2: back-to-back frames, no idle gap
    expect_done(8'hA5);
    expect_done(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    drain("t2_drain");
    check("t2_data", rx_data, 8'h3C);
    hold(BIT_CLKS);

    // 3: start-bit glitch of 12 clocks
    line = 1'b0;
    hold(8);
    check("t3_busy_high", busy, 1'b1);
    hold(4);
    line = 1'b1;
    hold(BIT_CLKS);
    check("t3_busy_low", busy, 1'b0);
    check("t3_data_kept", rx_data, model_data);
    hold(BIT_CLKS);

    // 4: low stop bit followed by a 5-bit-time break
    exp_q.push_back('{is_err: 1'b1, data: model_data});
    send_frame(8'hFF, 1'b0);
    hold(5 * BIT_CLKS);
    check("t4_busy_in_break", busy, 1'b1);
    line = 1'b1;
    hold(5);
    check("t4_busy_after_break", busy, 1'b0);
    drain("t4_drain");
    check("t4_data_kept", rx_data, model_data);
    hold(BIT_CLKS);

    // 5: reset during data bit 4 of 0x81, then a clean frame
    line = 1'b0;
    hold(BIT_CLKS);
    line = 1'b1;
    hold(BIT_CLKS);
    line = 1'b0;
    hold(3 * BIT_CLKS);
    hold(BIT_CLKS / 2);
    rst = 1'b1;
    line = 1'b1;
    hold(3);
    rst = 1'b0;
    model_data = 8'h00;
    hold(2);
    check("t5_data_after_reset", rx_data, 8'h00);
    check("t5_busy_after_reset", busy, 1'b0);
    hold(2 * BIT_CLKS);
    expect_done(8'h42);
    send_frame(8'h42, 1'b1);
    drain("t5_drain");
    check("t5_data", rx_data, 8'h42);
    hold(BIT_CLKS);

    // 6: extreme bit patterns
    expect_done(8'h00);
    send_frame(8'h00, 1'b1);
    drain("t6a_drain");
    check("t6a_data", rx_data, 8'h00);
    expect_done(8'hFF);
    send_frame(8'hFF, 1'b1);
    drain("t6b_drain");
    check("t6b_data", rx_data, 8'hFF);
    hold(2 * BIT_CLKS);
    check("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
UART receiver feeding the debug unit's command path. It synchronises the raw `i_uart_rx_data` pin and generates its own 16x oversampling tick. It deframes 8N1 characters (start, NB_DATA bits LSB first, one stop bit) and presents each received byte with a one-cycle done strobe. Framing errors and start-bit glitches are detected and reported.

Parameters:
- NB_DATA, 8, data bits per frame.
- CLK_FREQ, 50_000_000, i_clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- OVERSAMPLE, 16, ticks per bit (fixed at 16; other values unsupported).
- Derived DIVISOR = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer-truncated (325 at defaults); must be >= 2.

Ports:
- i_clock  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_uart_rx_data  input  1  raw serial line, idle high, asynchronous to i_clock.
- o_rx_data  output  NB_DATA  last correctly received byte.
- o_rx_done  output  1  one-cycle pulse when o_rx_data is updated.
- o_frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- o_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, active-high), applied immediately:
  - o_rx_data=0, o_rx_done=0, o_frame_error=0, o_busy=0.
  - State=IDLE; all counters=0; synchroniser flops=1.
- Synchroniser: two-flop chain on i_uart_rx_data; internal "rxs" = second flop. Input-to-rxs latency is 2 clocks.
- Tick generator:
  - Free-running counter 0..DIVISOR-1; tick=1 for one clock when counter==DIVISOR-1, then counter wraps to 0.
  - Runs continuously (not restarted per frame).
- Tick counter (4 bits, 0..15): cleared on every state transition.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rxs==0 (any clock, not only on tick), go to START.
- START:
  - On each tick, if tick count==7 (mid start bit):
    - rxs==0: go to DATA, bit index=0.
    - rxs==1: glitch; return to IDLE with no outputs.
  - Otherwise increment tick count.
- DATA:
  - On each tick, if tick count==15: shift rxs into the MSB of the shift register (right shift, so the LSB-first line order lands correctly) and increment bit index.
  - After bit NB_DATA-1, go to STOP.
  - Otherwise increment tick count.
- STOP:
  - On tick with tick count==15, sample rxs.
  - rxs==1:
    - o_rx_data<=shift register; o_rx_done=1 for exactly one clock; go to IDLE.
  - rxs==0:
    - o_frame_error=1 for one clock; o_rx_data unchanged; go to BREAK.
- BREAK: wait until rxs==1, then go to IDLE. A line held low (break) produces exactly one frame_error, not repeated frames.
- o_rx_done and o_frame_error are registered and never high together.
- o_rx_data holds its value until the next valid frame.
- Back-to-back frames: the return to IDLE happens mid stop bit, so a start edge that immediately follows the stop bit is caught. There are no dead cycles beyond the half stop bit.
- Reset asserted mid-frame aborts the frame. There is no done or error pulse after reset is released. The first frame after release is received normally provided the line has been high for >= 2 clocks.
- Baud tolerance: sampling at bit centre tolerates about ±4% total clock mismatch.

Test Plan:
(Bench overrides CLK_FREQ=640_000 and BAUD_RATE=10_000, giving DIVISOR=4 and 64 clocks per bit.)
1. Send 0x55 with a valid stop bit -> one o_rx_done pulse within 1 bit-time after stop-bit centre; o_rx_data=0x55; o_frame_error stays 0.
2. Send 0xA5 then 0x3C back-to-back with no idle gap -> two o_rx_done pulses; o_rx_data=0xA5, then 0x3C.
3. Drive the line low for 3 ticks (12 clocks), then high -> o_busy pulses and returns to 0; no o_rx_done; o_rx_data unchanged.
4. Send 0xFF with the stop bit driven low, then hold the line low for 5 bit-times, then release -> exactly one o_frame_error pulse; o_rx_data keeps its previous value; o_busy falls only after the line returns high.
5. Assert i_reset during data bit 4 of 0x81, deassert, then send 0x42 -> no pulse for the aborted frame; o_rx_data reads 0x00 after reset, then 0x42.
6. Send 0x00 and 0xFF -> o_rx_data=0x00, then 0xFF, each with a single o_rx_done pulse (checks the extreme bit patterns and the stop-bit check).
